// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for the multi-cycle datapath.
// Sequences fetch/decode/execute/memory/writeback and drives every datapath
// strobe, mux select and the 3-bit UCon class for the ALU control decoder.
// Memory states wait on MemReady, so multi-cycle memory is tolerated.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   Opcode[5:0]       instruction[31:26], sampled only in DECODE
//   Zero              ALU zero flag (branch decision)
//   MemReady          memory completes the current access this cycle
//   UCon[2:0]         ALU operation class
//   PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//   ALUSrcA, ALUSrcB[1:0], PCSrc[1:0]   datapath controls
//   Illegal           unsupported opcode seen in DECODE (one cycle)
//   State[3:0]        current state, for debug
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic [2:0] UCon,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       Illegal,
    output logic [3:0] State
);

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [2:0] UC_ADD   = 3'b000;
    localparam logic [2:0] UC_SUB   = 3'b001;
    localparam logic [2:0] UC_FUNCT = 3'b010;
    localparam logic [2:0] UC_ADDI  = 3'b011;
    localparam logic [2:0] UC_ANDI  = 3'b100;
    localparam logic [2:0] UC_ORI   = 3'b101;
    localparam logic [2:0] UC_SLTI  = 3'b110;

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_reg_q, op_reg_d;

    // State and captured opcode registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            op_reg_q <= '0;
        end else begin
            state_q  <= state_d;
            op_reg_q <= op_reg_d;
        end
    end

    // Next-state logic; opcode is latched only while decoding
    always_comb begin
        state_d  = state_q;
        op_reg_d = op_reg_q;
        case (state_q)
            S_FETCH: begin
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                op_reg_d = Opcode;
                case (Opcode)
                    OP_LW, OP_SW:                      state_d = S_MEMADR;
                    OP_RTYPE:                          state_d = S_RTEX;
                    OP_BEQ:                            state_d = S_BEQ;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMMEX;
                    OP_J:                              state_d = S_JUMP;
                    default:                           state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op_reg_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR: begin
                if (MemReady) state_d = S_FETCH;
            end
            S_RTEX:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_IMMEX:  state_d = S_IMMWB;
            S_IMMWB:  state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode from state and captured opcode
    always_comb begin
        UCon     = UC_ADD;
        PCEn     = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        PCSrc    = 2'b00;
        Illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCEn    = MemReady;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI,
                    OP_ANDI, OP_ORI, OP_SLTI, OP_J: Illegal = 1'b0;
                    default:                        Illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_RTEX: begin
                ALUSrcA = 1'b1;
                UCon    = UC_FUNCT;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 1'b1;
                UCon    = UC_SUB;
                PCSrc   = 2'b01;
                PCEn    = Zero;
            end
            S_IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (op_reg_q)
                    OP_ADDI: UCon = UC_ADDI;
                    OP_ANDI: UCon = UC_ANDI;
                    OP_ORI:  UCon = UC_ORI;
                    OP_SLTI: UCon = UC_SLTI;
                    default: UCon = UC_ADD;
                endcase
            end
            S_IMMWB: begin
                RegWrite = 1'b1;
            end
            S_JUMP: begin
                PCSrc = 2'b10;
                PCEn  = 1'b1;
            end
            default: begin
                UCon = UC_ADD;
            end
        endcase
        // Reset holds the FSM in FETCH; suppress every strobe meanwhile
        if (rst) begin
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            PCEn     = 1'b0;
            Illegal  = 1'b0;
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: per-cycle vector table with a scoreboard
// of expected output words, plus hand-written reset sequences.
module tb_multicycle_control;

    logic       clk;
    logic       rst;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic [2:0] UCon;
    logic       PCEn, IorD, MemRead, MemWrite, IRWrite;
    logic       RegDst, MemtoReg, RegWrite, ALUSrcA, Illegal;
    logic [1:0] ALUSrcB, PCSrc;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .UCon(UCon), .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .Illegal(Illegal), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus and its expected state / UCon / Illegal
    typedef struct {
        logic [5:0] op;
        logic       zero;
        logic       mr;
        logic [3:0] st;
        logic [2:0] ucon;
        logic       ill;
    } vec_t;

    // Output word: State,UCon,PCEn,IorD,MemRead,MemWrite,IRWrite,RegDst,
    // MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCSrc,Illegal
    logic [21:0] exp_q[$];

    function automatic logic [21:0] actual_word();
        return {State, UCon, PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst,
                MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSrc, Illegal};
    endfunction

    // Expected controls per state, taken from the state table
    function automatic logic [21:0] exp_word(vec_t v);
        logic pcen, iord, mrd, mwr, irw, rdst, m2r, rw, srca, ill;
        logic [1:0] srcb, pcsrc;
        {pcen, iord, mrd, mwr, irw, rdst, m2r, rw, srca} = '0;
        srcb = 2'b00; pcsrc = 2'b00; ill = v.ill;
        case (v.st)
            4'd0:  begin mrd = 1'b1; srcb = 2'b01; irw = v.mr; pcen = v.mr; end
            4'd1:  srcb = 2'b11;
            4'd2:  begin srca = 1'b1; srcb = 2'b10; end
            4'd3:  begin mrd = 1'b1; iord = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; end
            4'd5:  begin mwr = 1'b1; iord = 1'b1; end
            4'd6:  srca = 1'b1;
            4'd7:  begin rw = 1'b1; rdst = 1'b1; end
            4'd8:  begin srca = 1'b1; pcsrc = 2'b01; pcen = v.zero; end
            4'd9:  begin srca = 1'b1; srcb = 2'b10; end
            4'd10: rw = 1'b1;
            4'd11: begin pcsrc = 2'b10; pcen = 1'b1; end
            default: ;
        endcase
        return {v.st, v.ucon, pcen, iord, mrd, mwr, irw, rdst, m2r, rw, srca,
                srcb, pcsrc, ill};
    endfunction

    // Reset view: FETCH selects, all strobes low
    localparam logic [21:0] RESET_WORD = {4'd0, 3'd0, 9'b0, 2'b01, 2'b00, 1'b0};

    task automatic compare(input string name);
        logic [21:0] e, a;
        e = exp_q.pop_front();
        a = actual_word();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %06h want %06h", name, a, e);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        Opcode = v.op; Zero = v.zero; MemReady = v.mr;
        exp_q.push_back(exp_word(v));
        #1;
        compare(name);
    endtask

    vec_t vecs[$];

    task automatic add_v(input logic [5:0] op, input logic z, input logic mr,
                         input logic [3:0] st, input logic [2:0] uc, input logic ill);
        vec_t v;
        v.op = op; v.zero = z; v.mr = mr; v.st = st; v.ucon = uc; v.ill = ill;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; Opcode = 6'h00; Zero = 1'b0; MemReady = 1'b1;

        // add: 0,1,6,7 (MemReady low in non-memory states is ignored)
        add_v(6'h00, 0, 1, 0,  3'd0, 0);
        add_v(6'h00, 0, 0, 1,  3'd0, 0);
        add_v(6'h00, 0, 0, 6,  3'd2, 0);
        add_v(6'h00, 0, 1, 7,  3'd0, 0);
        // lw with two wait cycles in MEMRD
        add_v(6'h23, 0, 1, 0,  3'd0, 0);
        add_v(6'h23, 0, 1, 1,  3'd0, 0);
        add_v(6'h23, 0, 1, 2,  3'd0, 0);
        add_v(6'h23, 0, 0, 3,  3'd0, 0);
        add_v(6'h23, 0, 0, 3,  3'd0, 0);
        add_v(6'h23, 0, 1, 3,  3'd0, 0);
        add_v(6'h23, 0, 1, 4,  3'd0, 0);
        // beq taken, then not taken
        add_v(6'h04, 0, 1, 0,  3'd0, 0);
        add_v(6'h04, 0, 1, 1,  3'd0, 0);
        add_v(6'h04, 1, 1, 8,  3'd1, 0);
        add_v(6'h04, 0, 1, 0,  3'd0, 0);
        add_v(6'h04, 1, 1, 1,  3'd0, 0);
        add_v(6'h04, 0, 1, 8,  3'd1, 0);
        // addi, andi, ori, slti
        add_v(6'h08, 0, 1, 0,  3'd0, 0);
        add_v(6'h08, 0, 1, 1,  3'd0, 0);
        add_v(6'h08, 0, 1, 9,  3'd3, 0);
        add_v(6'h08, 0, 1, 10, 3'd0, 0);
        add_v(6'h0C, 0, 1, 0,  3'd0, 0);
        add_v(6'h0C, 0, 1, 1,  3'd0, 0);
        add_v(6'h0C, 0, 1, 9,  3'd4, 0);
        add_v(6'h0C, 0, 1, 10, 3'd0, 0);
        add_v(6'h0D, 0, 1, 0,  3'd0, 0);
        add_v(6'h0D, 0, 1, 1,  3'd0, 0);
        add_v(6'h0D, 0, 1, 9,  3'd5, 0);
        add_v(6'h0D, 0, 1, 10, 3'd0, 0);
        // slti with opcode changed during IMMEX/IMMWB: captured value wins
        add_v(6'h0A, 0, 1, 0,  3'd0, 0);
        add_v(6'h0A, 0, 1, 1,  3'd0, 0);
        add_v(6'h08, 0, 1, 9,  3'd6, 0);
        add_v(6'h3F, 0, 1, 10, 3'd0, 0);
        // illegal opcode: one cycle of Illegal in DECODE, back to FETCH
        add_v(6'h3F, 0, 1, 0,  3'd0, 0);
        add_v(6'h3F, 0, 1, 1,  3'd0, 1);
        // fetch stall for 3 cycles, then j
        add_v(6'h02, 0, 0, 0,  3'd0, 0);
        add_v(6'h02, 0, 0, 0,  3'd0, 0);
        add_v(6'h02, 0, 0, 0,  3'd0, 0);
        add_v(6'h02, 0, 1, 0,  3'd0, 0);
        add_v(6'h02, 0, 1, 1,  3'd0, 0);
        add_v(6'h02, 0, 1, 11, 3'd0, 0);
        // sw with no wait, then sw with one wait in MEMWR
        add_v(6'h2B, 0, 1, 0,  3'd0, 0);
        add_v(6'h2B, 0, 1, 1,  3'd0, 0);
        add_v(6'h2B, 0, 1, 2,  3'd0, 0);
        add_v(6'h2B, 0, 1, 5,  3'd0, 0);
        add_v(6'h2B, 0, 1, 0,  3'd0, 0);
        add_v(6'h2B, 0, 1, 1,  3'd0, 0);
        add_v(6'h2B, 0, 1, 2,  3'd0, 0);
        add_v(6'h2B, 0, 0, 5,  3'd0, 0);
        add_v(6'h2B, 0, 1, 5,  3'd0, 0);
        add_v(6'h00, 0, 1, 0,  3'd0, 0);

        // Reset asserted mid-cycle: FETCH view with strobes forced low
        @(posedge clk); @(posedge clk);
        #2;
        exp_q.push_back(RESET_WORD);
        #1;
        compare("reset_hold");

        // Release reset at a negedge, then run the vector table
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 0) begin
                Opcode = vecs[i].op; Zero = vecs[i].zero; MemReady = vecs[i].mr;
                exp_q.push_back(exp_word(vecs[i]));
                #1;
                compare("vec0");
            end else begin
                apply(vecs[i], $sformatf("vec%0d", i));
            end
        end

        // Reset mid-lw while MEMRD is waiting: abandons the access
        begin
            vec_t v;
            v.op = 6'h23; v.zero = 1'b0; v.mr = 1'b1; v.ucon = 3'd0; v.ill = 1'b0;
            v.st = 4'd1; apply(v, "rst_mid_decode");
            v.st = 4'd2; apply(v, "rst_mid_memadr");
            v.mr = 1'b0;
            v.st = 4'd3; apply(v, "rst_mid_memrd");
            #2;
            rst = 1'b1;
            MemReady = 1'b1;
            #1;
            exp_q.push_back(RESET_WORD);
            compare("rst_async");
            @(negedge clk);
            exp_q.push_back(RESET_WORD);
            #1;
            compare("rst_held_edge");
            rst = 1'b0;
            v.mr = 1'b1; v.st = 4'd0;
            exp_q.push_back(exp_word(v));
            #1;
            compare("rst_release_fetch");
            v.st = 4'd1; apply(v, "rst_after_decode");
        end

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
